// File: rtl/clock_pkg.sv
// Shared constants for the digital-clock time base, mood and display stages.
//  BCD_W     : width of one BCD digit
//  HOUR_MAX  : last valid hour value, two BCD digits (23)
//  MIN_MAX   : last valid minute value, two BCD digits (59)
//  SEC_MAX   : last valid second value, two BCD digits (59)
//  bcd2_inc  : increment a two-digit BCD value (caller handles the wrap)
package clock_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] SEC_MAX  = 8'h59;

    // Units roll 9 -> 0 with a carry into the tens digit.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter, counting 00..MAX and wrapping to 00.
//  CLK    in  1  clock, rising edge
//  RST    in  1  synchronous active-high reset (value -> 00)
//  CLR    in  1  synchronous clear to 00, takes priority over INC
//  INC    in  1  advance by one on this edge
//  TENS   out 4  registered tens digit
//  UNITS  out 4  registered units digit
//  WRAP   out 1  combinational: INC high while the value equals MAX
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             INC,
    output logic [BCD_W-1:0] TENS,
    output logic [BCD_W-1:0] UNITS,
    output logic             WRAP
);

    logic [7:0] val_q;
    logic [7:0] val_d;

    // Next value: clear, wrap at MAX, BCD increment, or hold.
    always_comb begin
        val_d = val_q;
        if (CLR) begin
            val_d = 8'h00;
        end else if (INC) begin
            if (val_q == MAX) begin
                val_d = 8'h00;
            end else begin
                val_d = bcd2_inc(val_q);
            end
        end else begin
            val_d = val_q;
        end
    end

    // Value register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            val_q <= 8'h00;
        end else begin
            val_q <= val_d;
        end
    end

    assign WRAP  = INC && (val_q == MAX);
    assign TENS  = val_q[7:4];
    assign UNITS = val_q[3:0];

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour BCD time base: prescales CLK to a 1 Hz tick and counts HH:MM:SS,
// with a set mode in which hour and minute are stepped by single-cycle pulses.
//  CLK       in  1  system clock, rising edge
//  RST       in  1  synchronous active-high reset
//  SET_EN    in  1  1 = set mode (time frozen, seconds held at 00)
//  INC_HOUR  in  1  hour +1 mod 24 in set mode
//  INC_MIN   in  1  minute +1 mod 60 in set mode (no carry into hours)
//  HOUR1/0   out 4  hour digits
//  MIN1/0    out 4  minute digits
//  SEC1/0    out 4  second digits
//  TICK_1HZ  out 1  one-cycle pulse at each prescaler terminal count
//  HOUR_CHG  out 1  one-cycle pulse on the edge the hour digits change
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SET_EN,
    input  logic             INC_HOUR,
    input  logic             INC_MIN,
    output logic [BCD_W-1:0] HOUR1,
    output logic [BCD_W-1:0] HOUR0,
    output logic [BCD_W-1:0] MIN1,
    output logic [BCD_W-1:0] MIN0,
    output logic [BCD_W-1:0] SEC1,
    output logic [BCD_W-1:0] SEC0,
    output logic             TICK_1HZ,
    output logic             HOUR_CHG
);

    localparam int               CTR_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CTR_W-1:0] CTR_TC = CTR_W'(CLK_HZ - 1);

    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic             tick_q, tick_d;
    logic             hour_chg_q, hour_chg_d;
    logic             sec_inc_s, min_inc_s, hour_inc_s;
    logic             sec_wrap_s, min_wrap_s, hour_wrap_s;

    // Prescaler and set-mode muxing of the counter increments. The tick's
    // digit update happens on the same edge that registers TICK_1HZ, so the
    // increments use the combinational terminal condition, not tick_q.
    always_comb begin
        ctr_d      = ctr_q;
        tick_d     = 1'b0;
        sec_inc_s  = 1'b0;
        min_inc_s  = 1'b0;
        hour_inc_s = 1'b0;
        if (SET_EN) begin
            ctr_d      = '0;
            tick_d     = 1'b0;
            min_inc_s  = INC_MIN;
            hour_inc_s = INC_HOUR;
        end else if (ctr_q == CTR_TC) begin
            ctr_d      = '0;
            tick_d     = 1'b1;
            sec_inc_s  = 1'b1;
            min_inc_s  = sec_wrap_s;
            hour_inc_s = min_wrap_s;
        end else begin
            ctr_d      = ctr_q + {{(CTR_W-1){1'b0}}, 1'b1};
            tick_d     = 1'b0;
        end
        // Every hour increment (including 23 -> 00) yields a new hour value.
        hour_chg_d = hour_inc_s;
    end

    // Prescaler and pulse registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ctr_q      <= '0;
            tick_q     <= 1'b0;
            hour_chg_q <= 1'b0;
        end else begin
            ctr_q      <= ctr_d;
            tick_q     <= tick_d;
            hour_chg_q <= hour_chg_d;
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .CLK   (CLK),
        .RST   (RST),
        .CLR   (SET_EN),
        .INC   (sec_inc_s),
        .TENS  (SEC1),
        .UNITS (SEC0),
        .WRAP  (sec_wrap_s)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .CLK   (CLK),
        .RST   (RST),
        .CLR   (1'b0),
        .INC   (min_inc_s),
        .TENS  (MIN1),
        .UNITS (MIN0),
        .WRAP  (min_wrap_s)
    );

    // Hour wrap has no consumer; 23 -> 00 is handled inside the counter.
    bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
        .CLK   (CLK),
        .RST   (RST),
        .CLR   (1'b0),
        .INC   (hour_inc_s),
        .TENS  (HOUR1),
        .UNITS (HOUR0),
        .WRAP  (hour_wrap_s)
    );

    assign TICK_1HZ = tick_q;
    assign HOUR_CHG = hour_chg_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
module tb_bcd_time_counter;

    localparam int HZ = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SET_EN = 1'b0;
    logic       INC_HOUR = 1'b0;
    logic       INC_MIN = 1'b0;
    logic [3:0] HOUR1, HOUR0, MIN1, MIN0, SEC1, SEC0;
    logic       TICK_1HZ, HOUR_CHG;

    bcd_time_counter #(.CLK_HZ(HZ)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SET_EN   (SET_EN),
        .INC_HOUR (INC_HOUR),
        .INC_MIN  (INC_MIN),
        .HOUR1    (HOUR1),
        .HOUR0    (HOUR0),
        .MIN1     (MIN1),
        .MIN0     (MIN0),
        .SEC1     (SEC1),
        .SEC0     (SEC0),
        .TICK_1HZ (TICK_1HZ),
        .HOUR_CHG (HOUR_CHG)
    );

    always #5 CLK = ~CLK;

    // Reference model: time as seconds-of-day plus a prescale count.
    int m_t = 0;
    int m_p = 0;
    bit m_tick = 1'b0;
    bit m_hchg = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [25:0] dut_vec;
    logic [23:0] dut_time;
    assign dut_time = {HOUR1, HOUR0, MIN1, MIN0, SEC1, SEC0};
    assign dut_vec  = {dut_time, TICK_1HZ, HOUR_CHG};

    function automatic logic [25:0] exp_vec();
        int h, m, s;
        h = m_t / 3600;
        m = (m_t / 60) % 60;
        s = m_t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), m_tick, m_hchg};
    endfunction

    // Drive one edge and advance the model by the same edge.
    task automatic step(input bit rst, input bit set, input bit ih, input bit im);
        int h, m, oh;
        RST = rst; SET_EN = set; INC_HOUR = ih; INC_MIN = im;
        @(posedge CLK);
        if (rst) begin
            m_t = 0; m_p = 0; m_tick = 1'b0; m_hchg = 1'b0;
        end else if (set) begin
            h = m_t / 3600;
            m = (m_t / 60) % 60;
            if (im) m = (m + 1) % 60;
            if (ih) h = (h + 1) % 24;
            m_t = h * 3600 + m * 60;
            m_p = 0; m_tick = 1'b0; m_hchg = ih;
        end else if (m_p == HZ - 1) begin
            oh = m_t / 3600;
            m_t = (m_t + 1) % 86400;
            m_p = 0; m_tick = 1'b1; m_hchg = ((m_t / 3600) != oh);
        end else begin
            m_p = m_p + 1; m_tick = 1'b0; m_hchg = 1'b0;
        end
        #1;
    endtask

    // Reach h:m:s by reset, set-mode pulses and then s run-mode seconds.
    task automatic preload(input int h, input int m, input int s);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < h; i++) step(0, 1, 1, 0);
        for (int i = 0; i < m; i++) step(0, 1, 0, 1);
        for (int i = 0; i < s * HZ; i++) begin
            step(0, 0, 0, 0);
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL preload cyc%0d: got %h want %h", i, dut_vec, exp_vec());
            end
            n_cmp++;
        end
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        if (dut_vec !== 26'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", dut_vec, 26'h0);
        end
        n_cmp++;
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0);
            if (TICK_1HZ !== (i == 4)) begin
                n_fail++;
                $display("FAIL first_tick edge%0d: got %b want %b", i, TICK_1HZ, (i == 4));
            end
            n_cmp++;
        end
        if (SEC0 !== 4'd1) begin
            n_fail++;
            $display("FAIL first_sec: got %0d want 1", SEC0);
        end
        n_cmp++;
    endtask

    task automatic test_rollover();
        int chg;
        chg = 0;
        preload(23, 59, 58);
        for (int i = 1; i <= 2 * HZ; i++) begin
            step(0, 0, 0, 0);
            chg += HOUR_CHG;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL rollover cyc%0d: got %h want %h", i, dut_vec, exp_vec());
            end
            n_cmp++;
            if (i == HZ) begin
                if (dut_time !== 24'h235959) begin
                    n_fail++;
                    $display("FAIL rollover_59: got %h want 235959", dut_time);
                end
                n_cmp++;
            end
        end
        if (dut_time !== 24'h000000 || chg != 1) begin
            n_fail++;
            $display("FAIL rollover_end: got %h chg=%0d want 000000 chg=1", dut_time, chg);
        end
        n_cmp++;
    endtask

    task automatic test_set_freeze();
        preload(12, 34, 56);
        step(0, 1, 0, 0);
        if (dut_time !== 24'h123400 || TICK_1HZ !== 1'b0) begin
            n_fail++;
            $display("FAIL set_enter: got %h tick=%b want 123400 tick=0", dut_time, TICK_1HZ);
        end
        n_cmp++;
        for (int i = 0; i < 26; i++) begin
            step(0, 1, 0, 1);
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL set_min cyc%0d: got %h want %h", i, dut_vec, exp_vec());
            end
            n_cmp++;
        end
        if (dut_time !== 24'h120000) begin
            n_fail++;
            $display("FAIL set_min_wrap: got %h want 120000", dut_time);
        end
        n_cmp++;
        for (int i = 1; i <= HZ; i++) begin
            step(0, 0, 0, 0);
            if (TICK_1HZ !== (i == HZ)) begin
                n_fail++;
                $display("FAIL set_exit_tick edge%0d: got %b want %b", i, TICK_1HZ, (i == HZ));
            end
            n_cmp++;
        end
    endtask

    task automatic test_dual_inc();
        preload(23, 59, 0);
        step(0, 1, 1, 1);
        if (dut_time !== 24'h000000 || HOUR_CHG !== 1'b1) begin
            n_fail++;
            $display("FAIL dual_inc: got %h chg=%b want 000000 chg=1", dut_time, HOUR_CHG);
        end
        n_cmp++;
        step(0, 1, 0, 0);
        if (HOUR_CHG !== 1'b0) begin
            n_fail++;
            $display("FAIL dual_inc_pulse: got %b want 0", HOUR_CHG);
        end
        n_cmp++;
    endtask

    task automatic test_run_ignore();
        step(1, 0, 0, 0);
        for (int i = 0; i < HZ - 1; i++) begin
            step(0, 0, 1, 1);
            if (dut_time !== 24'h0 || HOUR_CHG !== 1'b0) begin
                n_fail++;
                $display("FAIL run_ignore cyc%0d: got %h chg=%b want 000000 chg=0", i, dut_time, HOUR_CHG);
            end
            n_cmp++;
        end
    endtask

    task automatic test_mid_reset();
        preload(9, 15, 30);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        if (dut_vec !== 26'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h want 0", dut_vec);
        end
        n_cmp++;
        for (int i = 1; i <= HZ; i++) begin
            step(0, 0, 0, 0);
            if (TICK_1HZ !== (i == HZ)) begin
                n_fail++;
                $display("FAIL mid_reset_tick edge%0d: got %b want %b", i, TICK_1HZ, (i == HZ));
            end
            n_cmp++;
        end
    endtask

    task automatic test_random();
        bit set;
        set = 1'b0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 40) == 0) set = ~set;
            step($urandom_range(0, 400) == 0, set,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %h want %h", i, dut_vec, exp_vec());
            end
            n_cmp++;
        end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_set_freeze();
        test_dual_inc();
        test_run_ignore();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
